// File: rtl/ibex_pkg.sv
// Shared types for the register-file write-port controller.
package ibex_pkg;

  localparam int unsigned RfAddrW = 5;

  typedef enum logic {
    RF_WIPE = 1'b0,
    RF_RUN  = 1'b1
  } rf_wport_state_e;

endpackage

// File: rtl/ibex_rf_wport_ctrl.sv
// Arbitrates the register-file W1 port between writeback and a secondary requester,
// and zeroes the register file (except x0) after reset or on request.
//
// state   | meaning
// RF_WIPE | walking addresses 1..NUM_WORDS-1 writing WordZeroVal; primary writes dropped
// RF_RUN  | normal operation; primary wins, secondary takes idle cycles
module ibex_rf_wport_ctrl
  import ibex_pkg::*;
#(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter logic [DataWidth-1:0] WordZeroVal = '0,
  parameter int unsigned          StallLimit  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wipe_req_i,
  output logic                 wipe_busy_o,
  input  logic                 prim_we_i,
  input  logic [RfAddrW-1:0]   prim_waddr_i,
  input  logic [DataWidth-1:0] prim_wdata_i,
  input  logic                 sec_valid_i,
  input  logic [RfAddrW-1:0]   sec_waddr_i,
  input  logic [DataWidth-1:0] sec_wdata_i,
  output logic                 sec_ready_o,
  output logic                 prim_stall_o,
  output logic                 rf_we_o,
  output logic [RfAddrW-1:0]   rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 err_o
);

  localparam int unsigned NumWords = 2 ** (RV32E ? 4 : 5);
  localparam logic [RfAddrW-1:0] WipeLast = RfAddrW'(NumWords - 1);
  localparam logic [3:0] StallMax = 4'(StallLimit);

  rf_wport_state_e    state_q, state_d;
  logic [RfAddrW-1:0] wipe_cnt_q, wipe_cnt_d;
  logic [3:0]         stall_cnt_q, stall_cnt_d;
  logic               err_q, err_d;
  logic               sec_xfer;

  assign sec_xfer = sec_valid_i & sec_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RF_WIPE;
      wipe_cnt_q  <= RfAddrW'(1);
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wipe_cnt_q  <= wipe_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  // Wipe requests during a wipe are ignored; the counter is re-armed to 1 outside WIPE.
  always_comb begin
    state_d     = state_q;
    wipe_cnt_d  = RfAddrW'(1);
    stall_cnt_d = '0;
    err_d       = err_q;
    unique case (state_q)
      RF_WIPE: begin
        err_d = err_q | prim_we_i;
        if (wipe_cnt_q == WipeLast) begin
          state_d = RF_RUN;
        end else begin
          wipe_cnt_d = wipe_cnt_q + RfAddrW'(1);
        end
      end
      RF_RUN: begin
        if (wipe_req_i) begin
          state_d = RF_WIPE;
        end
        if (sec_valid_i && !sec_ready_o) begin
          stall_cnt_d = (stall_cnt_q == StallMax) ? stall_cnt_q : stall_cnt_q + 4'd1;
        end
      end
      default: state_d = RF_WIPE;
    endcase
  end

  always_comb begin
    wipe_busy_o  = 1'b0;
    sec_ready_o  = 1'b0;
    prim_stall_o = 1'b0;
    rf_we_o      = 1'b0;
    rf_waddr_o   = '0;
    rf_wdata_o   = '0;
    unique case (state_q)
      RF_WIPE: begin
        wipe_busy_o = 1'b1;
        rf_we_o     = 1'b1;
        rf_waddr_o  = wipe_cnt_q;
        rf_wdata_o  = WordZeroVal;
      end
      RF_RUN: begin
        sec_ready_o  = !prim_we_i;
        prim_stall_o = (stall_cnt_q == StallMax);
        if (prim_we_i) begin
          rf_we_o    = 1'b1;
          rf_waddr_o = prim_waddr_i;
          rf_wdata_o = prim_wdata_i;
        end else if (sec_xfer) begin
          rf_we_o    = 1'b1;
          rf_waddr_o = sec_waddr_i;
          rf_wdata_o = sec_wdata_i;
        end
      end
      default: ;
    endcase
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_ibex_rf_wport_ctrl.sv
// Directed bench for the register-file write-port controller (RV32E=0 and RV32E=1 instances).
module tb_ibex_rf_wport_ctrl;

  localparam int          DW = 32;
  localparam logic [31:0] WZ = 32'hA5A5_5A5A;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          rst_e_ni = 1'b0;
  logic          wipe_req_i = 1'b0;
  logic          prim_we_i = 1'b0;
  logic [4:0]    prim_waddr_i = '0;
  logic [DW-1:0] prim_wdata_i = '0;
  logic          sec_valid_i = 1'b0;
  logic [4:0]    sec_waddr_i = '0;
  logic [DW-1:0] sec_wdata_i = '0;

  logic          wipe_busy_o, sec_ready_o, prim_stall_o, rf_we_o, err_o;
  logic [4:0]    rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic          e_busy, e_ready, e_stall, e_we, e_err;
  logic [4:0]    e_waddr;
  logic [DW-1:0] e_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  ibex_rf_wport_ctrl #(.RV32E(1'b0), .DataWidth(DW), .WordZeroVal(WZ), .StallLimit(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .wipe_req_i(wipe_req_i), .wipe_busy_o(wipe_busy_o),
    .prim_we_i(prim_we_i), .prim_waddr_i(prim_waddr_i), .prim_wdata_i(prim_wdata_i),
    .sec_valid_i(sec_valid_i), .sec_waddr_i(sec_waddr_i), .sec_wdata_i(sec_wdata_i),
    .sec_ready_o(sec_ready_o), .prim_stall_o(prim_stall_o), .rf_we_o(rf_we_o),
    .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .err_o(err_o)
  );

  ibex_rf_wport_ctrl #(.RV32E(1'b1), .DataWidth(DW), .WordZeroVal('0), .StallLimit(4)) dut_e (
    .clk_i(clk_i), .rst_ni(rst_e_ni), .wipe_req_i(wipe_req_i), .wipe_busy_o(e_busy),
    .prim_we_i(prim_we_i), .prim_waddr_i(prim_waddr_i), .prim_wdata_i(prim_wdata_i),
    .sec_valid_i(sec_valid_i), .sec_waddr_i(sec_waddr_i), .sec_wdata_i(sec_wdata_i),
    .sec_ready_o(e_ready), .prim_stall_o(e_stall), .rf_we_o(e_we),
    .rf_waddr_o(e_waddr), .rf_wdata_o(e_wdata), .err_o(e_err)
  );

  task automatic test_reset();
    @(negedge clk_i); #2;
    checks++; if (rf_waddr_o !== 5'd1 || rf_we_o !== 1'b1 || wipe_busy_o !== 1'b1) begin
      errors++; $display("FAIL reset_wipe: we=%b addr=%0d busy=%b, want 1/1/1", rf_we_o, rf_waddr_o, wipe_busy_o);
    end
    checks++; if (sec_ready_o !== 1'b0 || prim_stall_o !== 1'b0 || err_o !== 1'b0) begin
      errors++; $display("FAIL reset_flags: ready=%b stall=%b err=%b, want 0/0/0", sec_ready_o, prim_stall_o, err_o);
    end
    @(posedge clk_i); #2;
    checks++; if (rf_waddr_o !== 5'd1) begin
      errors++; $display("FAIL reset_hold: addr=%0d, want 1", rf_waddr_o);
    end
    @(negedge clk_i); rst_ni = 1'b1; #2;
    checks++; if (rf_waddr_o !== 5'd1 || wipe_busy_o !== 1'b1) begin
      errors++; $display("FAIL reset_release: addr=%0d busy=%b, want 1/1", rf_waddr_o, wipe_busy_o);
    end
  endtask

  task automatic test_wipe_seq();
    for (int i = 1; i <= 31; i++) begin
      checks++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'(i) || rf_wdata_o !== WZ || wipe_busy_o !== 1'b1 || sec_ready_o !== 1'b0) begin
        errors++; $display("FAIL wipe_seq[%0d]: we=%b addr=%0d data=%h busy=%b ready=%b, want 1/%0d/%h/1/0",
                           i, rf_we_o, rf_waddr_o, rf_wdata_o, wipe_busy_o, sec_ready_o, i, WZ);
      end
      @(negedge clk_i); #2;
    end
    checks++; if (wipe_busy_o !== 1'b0 || sec_ready_o !== 1'b1 || rf_we_o !== 1'b0 || err_o !== 1'b0) begin
      errors++; $display("FAIL wipe_done: busy=%b ready=%b we=%b err=%b, want 0/1/0/0", wipe_busy_o, sec_ready_o, rf_we_o, err_o);
    end
  endtask

  task automatic test_prim_sec();
    prim_we_i = 1'b1; prim_waddr_i = 5'd5; prim_wdata_i = 32'h1111_0005;
    sec_valid_i = 1'b1; sec_waddr_i = 5'd7; sec_wdata_i = 32'h2222_0007;
    #1;
    checks++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd5 || rf_wdata_o !== 32'h1111_0005 || sec_ready_o !== 1'b0) begin
      errors++; $display("FAIL prim_wins: we=%b addr=%0d data=%h ready=%b, want 1/5/11110005/0", rf_we_o, rf_waddr_o, rf_wdata_o, sec_ready_o);
    end
    @(negedge clk_i); prim_we_i = 1'b0; #1;
    checks++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd7 || rf_wdata_o !== 32'h2222_0007 || sec_ready_o !== 1'b1) begin
      errors++; $display("FAIL sec_xfer: we=%b addr=%0d data=%h ready=%b, want 1/7/22220007/1", rf_we_o, rf_waddr_o, rf_wdata_o, sec_ready_o);
    end
    @(negedge clk_i); sec_valid_i = 1'b0; #1;
    checks++; if (rf_we_o !== 1'b0 || rf_waddr_o !== 5'd0 || rf_wdata_o !== '0 || prim_stall_o !== 1'b0) begin
      errors++; $display("FAIL idle: we=%b addr=%0d data=%h stall=%b, want 0/0/0/0", rf_we_o, rf_waddr_o, rf_wdata_o, prim_stall_o);
    end
    @(negedge clk_i); prim_we_i = 1'b1; prim_waddr_i = 5'd0; prim_wdata_i = 32'hCAFE_0000; #1;
    checks++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd0 || rf_wdata_o !== 32'hCAFE_0000) begin
      errors++; $display("FAIL prim_addr0: we=%b addr=%0d data=%h, want 1/0/cafe0000", rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    @(negedge clk_i); prim_we_i = 1'b0; sec_valid_i = 1'b1; sec_waddr_i = 5'd0; sec_wdata_i = 32'hBEEF_0000; #1;
    checks++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd0 || rf_wdata_o !== 32'hBEEF_0000) begin
      errors++; $display("FAIL sec_addr0: we=%b addr=%0d data=%h, want 1/0/beef0000", rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    @(negedge clk_i); sec_valid_i = 1'b0;
  endtask

  task automatic test_stall();
    prim_we_i = 1'b1; prim_waddr_i = 5'd3; prim_wdata_i = 32'h3333_3333;
    sec_valid_i = 1'b1; sec_waddr_i = 5'd9; sec_wdata_i = 32'h9999_9999;
    for (int c = 1; c <= 6; c++) begin
      #1;
      checks++; if (prim_stall_o !== (c >= 5) || rf_waddr_o !== 5'd3) begin
        errors++; $display("FAIL stall_cyc%0d: stall=%b addr=%0d, want %b/3", c, prim_stall_o, rf_waddr_o, c >= 5);
      end
      @(negedge clk_i);
    end
    prim_we_i = 1'b0; #1;
    checks++; if (sec_ready_o !== 1'b1 || rf_waddr_o !== 5'd9 || prim_stall_o !== 1'b1) begin
      errors++; $display("FAIL stall_xfer: ready=%b addr=%0d stall=%b, want 1/9/1", sec_ready_o, rf_waddr_o, prim_stall_o);
    end
    @(negedge clk_i); #1;
    checks++; if (prim_stall_o !== 1'b0) begin
      errors++; $display("FAIL stall_clear: stall=%b, want 0", prim_stall_o);
    end
    @(negedge clk_i); sec_valid_i = 1'b0;
  endtask

  task automatic test_wipe_err();
    wipe_req_i = 1'b1; prim_we_i = 1'b1; prim_waddr_i = 5'd9; prim_wdata_i = 32'h0000_0009; #1;
    checks++; if (rf_waddr_o !== 5'd9 || rf_wdata_o !== 32'h9 || wipe_busy_o !== 1'b0) begin
      errors++; $display("FAIL wipe_req_write: addr=%0d data=%h busy=%b, want 9/9/0", rf_waddr_o, rf_wdata_o, wipe_busy_o);
    end
    @(negedge clk_i); wipe_req_i = 1'b0; #1;
    checks++; if (wipe_busy_o !== 1'b1 || rf_waddr_o !== 5'd1 || rf_wdata_o !== WZ || err_o !== 1'b0) begin
      errors++; $display("FAIL wipe_drop: busy=%b addr=%0d data=%h err=%b, want 1/1/%h/0", wipe_busy_o, rf_waddr_o, rf_wdata_o, err_o, WZ);
    end
    @(negedge clk_i); prim_we_i = 1'b0; wipe_req_i = 1'b1; #1;
    checks++; if (err_o !== 1'b1 || rf_waddr_o !== 5'd2) begin
      errors++; $display("FAIL wipe_err_set: err=%b addr=%0d, want 1/2", err_o, rf_waddr_o);
    end
    @(negedge clk_i); wipe_req_i = 1'b0;
    for (int i = 3; i <= 31; i++) begin
      #1;
      checks++; if (rf_waddr_o !== 5'(i) || wipe_busy_o !== 1'b1) begin
        errors++; $display("FAIL rewipe[%0d]: addr=%0d busy=%b, want %0d/1", i, rf_waddr_o, wipe_busy_o, i);
      end
      @(negedge clk_i);
    end
    #1;
    checks++; if (wipe_busy_o !== 1'b0 || err_o !== 1'b1) begin
      errors++; $display("FAIL err_held: busy=%b err=%b, want 0/1", wipe_busy_o, err_o);
    end
  endtask

  task automatic test_rv32e();
    @(negedge clk_i); rst_e_ni = 1'b1; #1;
    for (int i = 1; i <= 8; i++) begin
      checks++; if (e_we !== 1'b1 || e_waddr !== 5'(i) || e_wdata !== '0) begin
        errors++; $display("FAIL e_wipe_pre[%0d]: we=%b addr=%0d data=%h, want 1/%0d/0", i, e_we, e_waddr, e_wdata, i);
      end
      if (i < 8) begin @(negedge clk_i); #1; end
    end
    rst_e_ni = 1'b0; #1;
    checks++; if (e_waddr !== 5'd1 || e_busy !== 1'b1) begin
      errors++; $display("FAIL e_reset_mid: addr=%0d busy=%b, want 1/1", e_waddr, e_busy);
    end
    @(negedge clk_i); rst_e_ni = 1'b1; #1;
    for (int i = 1; i <= 15; i++) begin
      checks++; if (e_waddr !== 5'(i) || e_busy !== 1'b1) begin
        errors++; $display("FAIL e_wipe[%0d]: addr=%0d busy=%b, want %0d/1", i, e_waddr, e_busy, i);
      end
      @(negedge clk_i); #1;
    end
    checks++; if (e_busy !== 1'b0 || e_ready !== 1'b1 || e_we !== 1'b0) begin
      errors++; $display("FAIL e_run: busy=%b ready=%b we=%b, want 0/1/0", e_busy, e_ready, e_we);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i); prim_we_i = 1'b1; sec_valid_i = 1'b1;
    @(negedge clk_i); @(negedge clk_i);
    rst_ni = 1'b0; #1;
    checks++; if (err_o !== 1'b0 || wipe_busy_o !== 1'b1 || rf_waddr_o !== 5'd1 || prim_stall_o !== 1'b0 || sec_ready_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid: err=%b busy=%b addr=%0d stall=%b ready=%b, want 0/1/1/0/0",
                         err_o, wipe_busy_o, rf_waddr_o, prim_stall_o, sec_ready_o);
    end
    prim_we_i = 1'b0; sec_valid_i = 1'b0;
    @(negedge clk_i); rst_ni = 1'b1; #1;
    checks++; if (rf_waddr_o !== 5'd1 || err_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid_release: addr=%0d err=%b, want 1/0", rf_waddr_o, err_o);
    end
  endtask

  initial begin
    test_reset();
    test_wipe_seq();
    @(negedge clk_i); #1;
    test_prim_sec();
    test_stall();
    test_wipe_err();
    test_rv32e();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_rf_wport_ctrl.md
IBEX_RF_WPORT_CTRL -- requirements
Module: ibex_rf_wport_ctrl

Interface
REQ-001 SHALL have parameter RV32E, default 0, meaning 16-word register file when 1, 32-word when 0; NUM_WORDS = 2**(RV32E ? 4 : 5).
REQ-002 SHALL have parameter DataWidth, default 32, meaning the register word width.
REQ-003 SHALL have parameter WordZeroVal, default '0, meaning the value written by a wipe.
REQ-004 SHALL have parameter StallLimit, default 4, meaning the number of consecutive blocked secondary cycles before a stall request; legal range 1..15.
REQ-005 clk_i  in  1  clock; all state on rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 wipe_req_i  in  1  request a full register-file wipe.
REQ-008 wipe_busy_o  out  1  wipe in progress.
REQ-009 prim_we_i, prim_waddr_i[4:0], prim_wdata_i[DataWidth-1:0]  in  primary (writeback) write; no backpressure.
REQ-010 sec_valid_i, sec_waddr_i[4:0], sec_wdata_i[DataWidth-1:0]  in  secondary (late load / coprocessor) write request.
REQ-011 sec_ready_o  out  1  secondary write accepted this cycle.
REQ-012 prim_stall_o  out  1  request to core to withhold primary writes next cycle.
REQ-013 rf_we_o, rf_waddr_o[4:0], rf_wdata_o[DataWidth-1:0]  out  register-file write port W1.
REQ-014 err_o  out  1  sticky error: primary write dropped during wipe.

Function
REQ-015 SHALL implement FSM states WIPE and RUN; reset state is WIPE.
REQ-016 In WIPE, a wipe counter SHALL start at 1 and drive rf_we_o=1, rf_waddr_o=counter, rf_wdata_o=WordZeroVal each cycle, incrementing by 1 per cycle.
REQ-017 WIPE SHALL transition to RUN on the cycle after the counter reaches NUM_WORDS-1 (31 writes for RV32E=0, 15 for RV32E=1); address 0 is never written by a wipe.
REQ-018 wipe_busy_o SHALL equal 1 exactly while in WIPE.
REQ-019 wipe_req_i in RUN SHALL enter WIPE next cycle with counter=1; wipe_req_i in WIPE SHALL be ignored (no restart).
REQ-020 In RUN, prim_we_i=1 SHALL win: rf_* = prim_*, same cycle (zero latency, combinational path).
REQ-021 sec_ready_o SHALL equal (state==RUN) & !prim_we_i; when sec_valid_i & sec_ready_o, rf_* = sec_* same cycle.
REQ-022 In RUN with neither write active, rf_we_o SHALL be 0 and rf_waddr_o/rf_wdata_o SHALL be 0.
REQ-023 Writes to address 0 from either requester SHALL be passed through unchanged; no address filtering.
REQ-024 prim_we_i in WIPE SHALL be dropped (no write) and set err_o on the next edge; err_o holds 1 until reset.
REQ-025 Stall counter SHALL increment each RUN cycle with sec_valid_i & !sec_ready_o, saturate at StallLimit, and clear on secondary transfer, on !sec_valid_i, or in WIPE.
REQ-026 prim_stall_o SHALL equal (stall counter == StallLimit) & (state==RUN); primary still wins if prim_we_i arrives regardless.
REQ-027 wipe_req_i coincident with a primary or secondary write in RUN SHALL let that write complete this cycle; the wipe begins next cycle.

Reset
REQ-028 During and immediately after reset: state WIPE, counter 1, stall counter 0, err_o 0, wipe_busy_o 1, rf_we_o 1, rf_waddr_o 1, sec_ready_o 0, prim_stall_o 0.
REQ-029 Reset asserted mid-wipe or mid-stall SHALL restart from the REQ-028 state.

Structure
REQ-030 The FSM state enum (rf_wport_state_e: RF_WIPE, RF_RUN) SHALL live in ibex_pkg; StallLimit width is derived locally (4 bits).
REQ-031 No sub-module is required; FSM, wipe counter and stall counter are implemented inline.

Verification
REQ-032 Reset release, RV32E=0 -> rf_we_o=1 with addresses 1..31 on 31 consecutive cycles, data WordZeroVal, then wipe_busy_o=0 and sec_ready_o=1 on cycle 32.
REQ-033 RUN: prim_we_i=1 addr 5 and sec_valid_i=1 addr 7 simultaneously -> rf_waddr_o=5, sec_ready_o=0; next cycle prim_we_i=0 -> rf_waddr_o=7, sec_ready_o=1.
REQ-034 StallLimit=4, sec_valid_i held, prim_we_i held 1 -> prim_stall_o=1 on the 5th cycle; drop prim_we_i -> transfer, prim_stall_o=0 next cycle.
REQ-035 RUN: wipe_req_i=1 -> wipe_busy_o=1 next cycle; prim_we_i=1 during wipe -> no primary write, err_o=1 next cycle and held.
REQ-036 RV32E=1 -> wipe writes addresses 1..15 only, RUN after 15 cycles; reset asserted at wipe address 8 -> restart at address 1.
